// File: rtl/stage_m_pkg.sv
// -----------------------------------------------------------------------------
// stage_m_pkg
// Shared definitions for the memory stage:
//   - major opcodes of the load/store instructions
//   - 2-bit access size encoding
//   - exception vector used by the misalignment trap
//   - FSM state type and small opcode decode helpers
// -----------------------------------------------------------------------------
package stage_m_pkg;

   // Load/store major opcodes (same values as the asm.v defines)
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   function automatic logic is_load(input logic [5:0] op);
      return op[5:3] == 3'b100;
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return op[5:3] == 3'b101;
   endfunction

   function automatic size_e op_size(input logic [5:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: return SZ_HALF;
         OP_LW, OP_SW:         return SZ_WORD;
         default:              return SZ_WORD;
      endcase
   endfunction

   function automatic logic op_signed(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH);
   endfunction

   // Half accesses need ea[0] = 0, word accesses need ea[1:0] = 0.
   function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
      case (sz)
         SZ_HALF: return lo[0];
         SZ_WORD: return |lo;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/stage_m_if.sv
// -----------------------------------------------------------------------------
// stage_m_if
// Data-memory req/ack port of the memory stage.
//   dmem_req   request, held until ack       (master -> slave)
//   dmem_addr  word address, [1:0] = 0       (master -> slave)
//   dmem_wr    1 = store                     (master -> slave)
//   dmem_wdata lane-replicated store data    (master -> slave)
//   dmem_be    byte enables, bit 3 = [31:24] (master -> slave)
//   dmem_rdata load data, valid with ack     (slave -> master)
//   dmem_ack   single-cycle completion       (slave -> master)
// -----------------------------------------------------------------------------
interface stage_m_if;
   logic        dmem_req;
   logic [31:0] dmem_addr;
   logic        dmem_wr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_addr, dmem_wr, dmem_wdata, dmem_be,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_addr, dmem_wr, dmem_wdata, dmem_be,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/stage_m_load_align.sv
// -----------------------------------------------------------------------------
// stage_m_load_align
// Big-endian lane select plus sign/zero extension of load data.
//   rdata    in  32  raw word from data memory
//   size     in  2   access size (size_e)
//   sign_ext in  1   1 = sign-extend byte/half
//   ea_lo    in  2   effective address bits [1:0]
//   data     out 32  aligned, extended load result
// -----------------------------------------------------------------------------
module stage_m_load_align
   import stage_m_pkg::*;
(
   input  logic [31:0] rdata,
   input  size_e       size,
   input  logic        sign_ext,
   input  logic [1:0]  ea_lo,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // NOTE: every output of a combinational block gets a value on every path,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      // Byte k lives at rdata[31-8k -: 8] (big-endian)
      case (ea_lo)
         2'd0:    byte_lane = rdata[31:24];
         2'd1:    byte_lane = rdata[23:16];
         2'd2:    byte_lane = rdata[15:8];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = ea_lo[1] ? rdata[15:0] : rdata[31:16];

      case (size)
         SZ_BYTE: data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
         SZ_HALF: data = {{16{sign_ext & half_lane[15]}}, half_lane};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/stage_m.sv
// -----------------------------------------------------------------------------
// stage_m
// Memory stage: computes the load/store effective address, runs the req/ack
// data-memory handshake, aligns load data and produces the writeback record.
// Upstream is stalled while an access is outstanding.
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   x_*                   execute-stage record (valid, instr, pc, opcode,
//                         base value, store data, dest reg, ALU result)
//   dmem                  data-memory port (stage_m_if.master)
//   m_stall               freeze D and X this cycle (combinational from state)
//   m_valid/m_wbr/m_res   writeback record
//   m_restart/_pc         restart request and target (trap only)
//
// Build option: MISALIGN_TRAP_EN -- misaligned half/word accesses trap to
// RESET_PC_VECTOR instead of using the truncated natural lane.
// -----------------------------------------------------------------------------
module stage_m
   import stage_m_pkg::*;
#(
   parameter logic [31:0] RESET_PC_VECTOR = EXC_VECTOR
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        x_valid,
   input  logic [31:0] x_instr,
   input  logic [31:0] x_pc,
   input  logic [5:0]  x_opcode,
   input  logic [31:0] x_op1_val,
   input  logic [31:0] x_rt_val,
   input  logic [5:0]  x_wbr,
   input  logic [31:0] x_res,
   stage_m_if.master   dmem,
   output logic        m_stall,
   output logic        m_valid,
   output logic [5:0]  m_wbr,
   output logic [31:0] m_res,
   output logic        m_restart,
   output logic [31:0] m_restart_pc
);

   state_e      state;
   logic [1:0]  ea_lo_q;
   size_e       size_q;
   logic        signed_q;
   logic [5:0]  wbr_q;
   logic [31:0] pc_q;
`ifdef MISALIGN_TRAP_EN
   logic [31:0] m_badpc;
`endif

   logic [31:0] ea;
   logic        x_load;
   logic        x_store;
   logic        x_mem;
   size_e       x_size;
   logic        trap;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] load_data;

   assign ea      = x_op1_val + {{16{x_instr[15]}}, x_instr[15:0]};
   assign x_load  = is_load(x_opcode);
   assign x_store = is_store(x_opcode);
   assign x_mem   = x_valid & (x_load | x_store);
   assign x_size  = op_size(x_opcode);

`ifdef MISALIGN_TRAP_EN
   assign trap = x_mem & misaligned(x_size, ea[1:0]);
`else
   assign trap = 1'b0;
`endif

   assign m_stall = (state == S_WAIT);

   // Store lane enables and replicated data; loads read the whole word.
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = x_rt_val;
      if (x_store) begin
         case (x_size)
            SZ_BYTE: begin
               be_c    = 4'b1000 >> ea[1:0];
               wdata_c = {4{x_rt_val[7:0]}};
            end
            SZ_HALF: begin
               be_c    = ea[1] ? 4'b0011 : 4'b1100;
               wdata_c = {2{x_rt_val[15:0]}};
            end
            default: ;
         endcase
      end
   end

   stage_m_load_align u_load_align (
      .rdata    (dmem.dmem_rdata),
      .size     (size_q),
      .sign_ext (signed_q),
      .ea_lo    (ea_lo_q),
      .data     (load_data)
   );

   // NOTE: state is updated with non-blocking assignments and every register,
   // including the latched access context, is cleared by the asynchronous
   // reset so that an access interrupted by reset leaves nothing behind.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IDLE;
         ea_lo_q         <= 2'b00;
         size_q          <= SZ_BYTE;
         signed_q        <= 1'b0;
         wbr_q           <= 6'd0;
         pc_q            <= 32'd0;
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_addr  <= 32'd0;
         dmem.dmem_wr    <= 1'b0;
         dmem.dmem_wdata <= 32'd0;
         dmem.dmem_be    <= 4'b0000;
         m_valid         <= 1'b0;
         m_wbr           <= 6'd0;
         m_res           <= 32'd0;
         m_restart       <= 1'b0;
         m_restart_pc    <= 32'd0;
`ifdef MISALIGN_TRAP_EN
         m_badpc         <= 32'd0;
`endif
      end else begin
         m_restart    <= 1'b0;
         m_restart_pc <= 32'd0;
         case (state)
            S_IDLE: begin
               // Any ack seen here belongs to no access and is ignored.
               if (trap) begin
                  m_valid      <= 1'b0;
                  m_restart    <= 1'b1;
                  m_restart_pc <= RESET_PC_VECTOR;
`ifdef MISALIGN_TRAP_EN
                  m_badpc      <= x_pc;
`endif
               end else if (x_mem) begin
                  ea_lo_q         <= ea[1:0];
                  size_q          <= x_size;
                  signed_q        <= op_signed(x_opcode);
                  wbr_q           <= x_wbr;
                  pc_q            <= x_pc;
                  dmem.dmem_req   <= 1'b1;
                  dmem.dmem_addr  <= {ea[31:2], 2'b00};
                  dmem.dmem_wr    <= x_store;
                  dmem.dmem_be    <= be_c;
                  dmem.dmem_wdata <= wdata_c;
                  m_valid         <= 1'b0;
                  state           <= S_WAIT;
               end else begin
                  m_valid <= x_valid;
                  m_wbr   <= x_wbr;
                  m_res   <= x_res;
               end
            end
            S_WAIT: begin
               // Address, data and enables hold; only the ack edge moves on.
               if (dmem.dmem_ack) begin
                  dmem.dmem_req <= 1'b0;
                  m_valid       <= 1'b1;
                  state         <= S_IDLE;
                  if (dmem.dmem_wr) begin
                     m_wbr <= 6'd0;
                  end else begin
                     m_wbr <= wbr_q;
                     m_res <= load_data;
                  end
               end
            end
         endcase
      end
   end

   // Context kept for debug visibility only; x_instr[31:16] carries no offset.
   logic unused_ok;
`ifdef MISALIGN_TRAP_EN
   assign unused_ok = &{1'b0, x_instr[31:16], pc_q, m_badpc};
`else
   assign unused_ok = &{1'b0, x_instr[31:16], pc_q};
`endif

endmodule

// File: tb/tb_stage_m.sv
// -----------------------------------------------------------------------------
// tb_stage_m
// Directed, table-driven bench for stage_m plus hand-written sequences for
// the multi-cycle stall, reset-during-access and misalignment cases.
// -----------------------------------------------------------------------------
module tb_stage_m;
   import stage_m_pkg::*;

   localparam int K_ALU   = 0;
   localparam int K_LOAD  = 1;
   localparam int K_STORE = 2;

   logic        clock;
   logic        reset_n;
   logic        x_valid;
   logic [31:0] x_instr;
   logic [31:0] x_pc;
   logic [5:0]  x_opcode;
   logic [31:0] x_op1_val;
   logic [31:0] x_rt_val;
   logic [5:0]  x_wbr;
   logic [31:0] x_res;
   logic        m_stall;
   logic        m_valid;
   logic [5:0]  m_wbr;
   logic [31:0] m_res;
   logic        m_restart;
   logic [31:0] m_restart_pc;

   stage_m_if dmem ();

   stage_m dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .x_valid      (x_valid),
      .x_instr      (x_instr),
      .x_pc         (x_pc),
      .x_opcode     (x_opcode),
      .x_op1_val    (x_op1_val),
      .x_rt_val     (x_rt_val),
      .x_wbr        (x_wbr),
      .x_res        (x_res),
      .dmem         (dmem),
      .m_stall      (m_stall),
      .m_valid      (m_valid),
      .m_wbr        (m_wbr),
      .m_res        (m_res),
      .m_restart    (m_restart),
      .m_restart_pc (m_restart_pc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   // Advance one cycle and settle past the active edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] base,
                        input logic [15:0] off, input logic [31:0] rt,
                        input logic [5:0] wbr, input logic [31:0] res);
      x_valid   = v;
      x_opcode  = op;
      x_op1_val = base;
      x_instr   = {op, 10'h155, off};
      x_rt_val  = rt;
      x_wbr     = wbr;
      x_res     = res;
      x_pc      = x_pc + 32'd4;
   endtask

   typedef struct {
      int          kind;
      logic        valid;
      logic [5:0]  op;
      logic [31:0] base;
      logic [15:0] off;
      logic [31:0] rt;
      logic [5:0]  wbr;
      logic [31:0] res;
      logic [31:0] rdata;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic        e_valid;
      logic [5:0]  e_wbr;
      logic [31:0] e_res;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   initial begin
      vec_t v;
      int   stall_cnt;

      //            kind     vld  op     base          off       rt            wbr    res           rdata         e_addr        be       e_wdata       e_v  e_wbr  e_res
      vecs[0]  = '{K_ALU,   1'b1, 6'h00, 32'h0,        16'h0000, 32'h0,        6'd5,  32'h12345678, 32'h0,        32'h0,        4'h0,    32'h0,        1'b1, 6'd5,  32'h12345678};
      vecs[1]  = '{K_LOAD,  1'b1, OP_LB, 32'h00001000, 16'hFFFF, 32'h0,        6'd2,  32'h0,        32'h000000F0, 32'h00000FFC, 4'b1111, 32'h0,        1'b1, 6'd2,  32'hFFFFFFF0};
      vecs[2]  = '{K_LOAD,  1'b1, OP_LBU,32'h00001000, 16'hFFFF, 32'h0,        6'd3,  32'h0,        32'h000000F0, 32'h00000FFC, 4'b1111, 32'h0,        1'b1, 6'd3,  32'h000000F0};
      vecs[3]  = '{K_STORE, 1'b1, OP_SH, 32'h00002000, 16'h0002, 32'hABCDBEEF, 6'd7,  32'h0,        32'h0,        32'h00002000, 4'b0011, 32'hBEEFBEEF, 1'b1, 6'd0,  32'h0};
      vecs[4]  = '{K_LOAD,  1'b1, OP_LH, 32'h00002000, 16'h0002, 32'h0,        6'd8,  32'h0,        32'h12348765, 32'h00002000, 4'b1111, 32'h0,        1'b1, 6'd8,  32'hFFFF8765};
      vecs[5]  = '{K_LOAD,  1'b1, OP_LHU,32'h00002004, 16'hFFFC, 32'h0,        6'd9,  32'h0,        32'h87651234, 32'h00002000, 4'b1111, 32'h0,        1'b1, 6'd9,  32'h00008765};
      vecs[6]  = '{K_LOAD,  1'b1, OP_LW, 32'h00003000, 16'hFFFC, 32'h0,        6'd10, 32'h0,        32'hDEADBEEF, 32'h00002FFC, 4'b1111, 32'h0,        1'b1, 6'd10, 32'hDEADBEEF};
      vecs[7]  = '{K_STORE, 1'b1, OP_SB, 32'h00004000, 16'h0001, 32'h000000A5, 6'd11, 32'h0,        32'h0,        32'h00004000, 4'b0100, 32'hA5A5A5A5, 1'b1, 6'd0,  32'h0};
      vecs[8]  = '{K_STORE, 1'b1, OP_SB, 32'h00004000, 16'h0003, 32'h1234565A, 6'd11, 32'h0,        32'h0,        32'h00004000, 4'b0001, 32'h5A5A5A5A, 1'b1, 6'd0,  32'h0};
      vecs[9]  = '{K_STORE, 1'b1, OP_SW, 32'h00000010, 16'h0000, 32'hCAFEF00D, 6'd12, 32'h0,        32'h0,        32'h00000010, 4'b1111, 32'hCAFEF00D, 1'b1, 6'd0,  32'h0};
      vecs[10] = '{K_STORE, 1'b1, OP_SH, 32'h00002000, 16'h0000, 32'h00001357, 6'd12, 32'h0,        32'h0,        32'h00002000, 4'b1100, 32'h13571357, 1'b1, 6'd0,  32'h0};
      vecs[11] = '{K_LOAD,  1'b1, OP_LB, 32'h00001000, 16'h0001, 32'h0,        6'd13, 32'h0,        32'h117F2233, 32'h00001000, 4'b1111, 32'h0,        1'b1, 6'd13, 32'h0000007F};
      vecs[12] = '{K_ALU,   1'b0, OP_LW, 32'h00005000, 16'h0000, 32'h0,        6'd3,  32'hAAAA5555, 32'h0,        32'h0,        4'h0,    32'h0,        1'b0, 6'd3,  32'hAAAA5555};
      vecs[13] = '{K_ALU,   1'b1, 6'h00, 32'h0,        16'h0000, 32'h0,        6'd31, 32'hFFFFFFFF, 32'h0,        32'h0,        4'h0,    32'h0,        1'b1, 6'd31, 32'hFFFFFFFF};

      // ---- reset state ----
      reset_n         = 1'b0;
      x_pc            = 32'h00400000;
      drive(1'b0, 6'h00, 32'h0, 16'h0, 32'h0, 6'd0, 32'h0);
      dmem.dmem_rdata = 32'h0;
      dmem.dmem_ack   = 1'b0;
      #12;
      check("rst_req",     {31'd0, dmem.dmem_req}, 32'd0);
      check("rst_stall",   {31'd0, m_stall}, 32'd0);
      check("rst_valid",   {31'd0, m_valid}, 32'd0);
      check("rst_wbr",     {26'd0, m_wbr}, 32'd0);
      check("rst_res",     m_res, 32'd0);
      check("rst_restart", {31'd0, m_restart}, 32'd0);
      reset_n = 1'b1;
      tick();

      // ---- table-driven vectors ----
      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         drive(v.valid, v.op, v.base, v.off, v.rt, v.wbr, v.res);
         tick();
         if (v.kind == K_ALU) begin
            check($sformatf("v%0d_valid", i), {31'd0, m_valid}, {31'd0, v.e_valid});
            check($sformatf("v%0d_wbr", i),   {26'd0, m_wbr}, {26'd0, v.e_wbr});
            check($sformatf("v%0d_res", i),   m_res, v.e_res);
            check($sformatf("v%0d_stall", i), {31'd0, m_stall}, 32'd0);
            check($sformatf("v%0d_req", i),   {31'd0, dmem.dmem_req}, 32'd0);
         end else begin
            check($sformatf("v%0d_req", i),   {31'd0, dmem.dmem_req}, 32'd1);
            check($sformatf("v%0d_addr", i),  dmem.dmem_addr, v.e_addr);
            check($sformatf("v%0d_wr", i),    {31'd0, dmem.dmem_wr}, (v.kind == K_STORE) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_be", i),    {28'd0, dmem.dmem_be}, {28'd0, v.e_be});
            check($sformatf("v%0d_stall", i), {31'd0, m_stall}, 32'd1);
            check($sformatf("v%0d_mv0", i),   {31'd0, m_valid}, 32'd0);
            if (v.kind == K_STORE)
               check($sformatf("v%0d_wdata", i), dmem.dmem_wdata, v.e_wdata);
            x_valid         = 1'b0;
            dmem.dmem_rdata = v.rdata;
            dmem.dmem_ack   = 1'b1;
            tick();
            dmem.dmem_ack   = 1'b0;
            check($sformatf("v%0d_req_done", i), {31'd0, dmem.dmem_req}, 32'd0);
            check($sformatf("v%0d_valid", i),    {31'd0, m_valid}, {31'd0, v.e_valid});
            check($sformatf("v%0d_wbr", i),      {26'd0, m_wbr}, {26'd0, v.e_wbr});
            if (v.kind == K_LOAD)
               check($sformatf("v%0d_res", i), m_res, v.e_res);
            check($sformatf("v%0d_stall_done", i), {31'd0, m_stall}, 32'd0);
            check($sformatf("v%0d_restart", i),    {31'd0, m_restart}, 32'd0);
         end
      end

      // ---- LW with ack three cycles after the request ----
      drive(1'b1, OP_LW, 32'h00000100, 16'h0004, 32'h0, 6'd20, 32'h0);
      tick();
      stall_cnt = 0;
      // Next upstream record is presented and must be held through the stall
      drive(1'b1, 6'h00, 32'h0, 16'h0, 32'h0, 6'd12, 32'h00000055);
      for (int c = 0; c < 3; c++) begin
         if (m_stall) stall_cnt++;
         check($sformatf("lw3_mv0_%0d", c), {31'd0, m_valid}, 32'd0);
         check($sformatf("lw3_addr_%0d", c), dmem.dmem_addr, 32'h00000104);
         tick();
      end
      if (m_stall) stall_cnt++;
      dmem.dmem_rdata = 32'h0BADF00D;
      dmem.dmem_ack   = 1'b1;
      tick();
      dmem.dmem_ack   = 1'b0;
      check("lw3_stall_cycles", stall_cnt, 32'd4);
      check("lw3_valid", {31'd0, m_valid}, 32'd1);
      check("lw3_wbr",   {26'd0, m_wbr}, 32'd20);
      check("lw3_res",   m_res, 32'h0BADF00D);
      check("lw3_stall_off", {31'd0, m_stall}, 32'd0);
      tick();
      check("held_valid", {31'd0, m_valid}, 32'd1);
      check("held_wbr",   {26'd0, m_wbr}, 32'd12);
      check("held_res",   m_res, 32'h00000055);
      x_valid = 1'b0;
      tick();
      check("held_once", {31'd0, m_valid}, 32'd0);

      // ---- reset during WAIT, then a stray ack ----
      drive(1'b1, OP_LW, 32'h00000200, 16'h0000, 32'h0, 6'd21, 32'h0);
      tick();
      check("rw_req_set", {31'd0, dmem.dmem_req}, 32'd1);
      x_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("rw_req_drop", {31'd0, dmem.dmem_req}, 32'd0);
      check("rw_stall_drop", {31'd0, m_stall}, 32'd0);
      #1 reset_n = 1'b1;
      dmem.dmem_rdata = 32'hFFFFFFFF;
      dmem.dmem_ack   = 1'b1;
      tick();
      dmem.dmem_ack   = 1'b0;
      check("rw_valid", {31'd0, m_valid}, 32'd0);
      check("rw_idle",  {31'd0, m_stall}, 32'd0);
      check("rw_req",   {31'd0, dmem.dmem_req}, 32'd0);

      // ---- misaligned LW, ea = 32'h1001 ----
      drive(1'b1, OP_LW, 32'h00001000, 16'h0001, 32'h0, 6'd22, 32'h0);
      tick();
`ifdef MISALIGN_TRAP_EN
      x_valid = 1'b0;
      check("trap_req",     {31'd0, dmem.dmem_req}, 32'd0);
      check("trap_stall",   {31'd0, m_stall}, 32'd0);
      check("trap_valid",   {31'd0, m_valid}, 32'd0);
      check("trap_restart", {31'd0, m_restart}, 32'd1);
      check("trap_pc",      m_restart_pc, 32'hBFC00380);
      tick();
      check("trap_pulse",   {31'd0, m_restart}, 32'd0);
      check("trap_req2",    {31'd0, dmem.dmem_req}, 32'd0);
`else
      x_valid = 1'b0;
      check("mis_req",     {31'd0, dmem.dmem_req}, 32'd1);
      check("mis_addr",    dmem.dmem_addr, 32'h00001000);
      check("mis_restart", {31'd0, m_restart}, 32'd0);
      dmem.dmem_rdata = 32'h01020304;
      dmem.dmem_ack   = 1'b1;
      tick();
      dmem.dmem_ack   = 1'b0;
      check("mis_res",     m_res, 32'h01020304);
      check("mis_restart2", {31'd0, m_restart}, 32'd0);
      check("mis_rpc",     m_restart_pc, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/stage_m.md
Name: stage_M

Overview:
- Memory stage, directly downstream of the execute stage.
- Consumes the execute stage's registered outputs and computes the effective address for loads and stores.
- Runs a req/ack handshake on the data-memory port and aligns and extends load data.
- Produces the writeback record and the m_valid/m_wbr pair that the execute stage and forwarding logic consume. Stalls upstream while an access is outstanding.

Parameters:
- RESET_PC_VECTOR, 32'hBFC00380: exception vector used only by the misalign trap.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- x_valid  in  1  EX record valid.
- x_instr  in  32  instruction; [15:0] is the load/store offset.
- x_pc  in  32  instruction PC.
- x_opcode  in  6  major opcode.
- x_op1_val  in  32  base register value.
- x_rt_val  in  32  store data.
- x_wbr  in  6  destination register; 0 = none.
- x_res  in  32  ALU result for non-memory ops.
- dmem_req  out  1  access request, held until ack.
- dmem_addr  out  32  word address; [1:0] = 0.
- dmem_wr  out  1  1 = store.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables; bit 3 = bits 31:24.
- dmem_rdata  in  32  load data, valid with ack.
- dmem_ack  in  1  single-cycle completion.
- m_stall  out  1  freeze D and X this cycle.
- m_valid  out  1  writeback record valid.
- m_wbr  out  6  writeback register.
- m_res  out  32  writeback value.
- m_restart  out  1  restart request (trap only).
- m_restart_pc  out  32  restart target.

Behaviour:
- Reset:
  - Asynchronous, active-low; the clock is named clock and the reset reset_n.
  - All registered outputs are cleared to 0 and state goes to IDLE.
  - A reset during WAIT abandons the access, drops dmem_req immediately, and discards any later ack.
- Memop decode: x_opcode[5:3] == 3'b100 is a load (LB 20, LH 21, LW 23, LBU 24, LHU 25). x_opcode[5:3] == 3'b101 is a store (SB 28, SH 29, SW 2B).
- Effective address: ea = x_op1_val + sign_extend(x_instr[15:0]), 32-bit wrap-around.
- State IDLE:
  - Non-memop, or x_valid = 0: at the next edge m_valid <= x_valid, m_wbr <= x_wbr, m_res <= x_res. Latency is 1 cycle.
  - Valid memop: at the next edge the block latches ea[1:0], opcode, wbr and PC. It drives dmem_req = 1, dmem_addr = {ea[31:2], 2'b00} and dmem_wr, sets m_valid <= 0, and goes to WAIT.
- State WAIT:
  - m_stall = 1 for every WAIT cycle, including the ack cycle. m_stall is 0 in IDLE and is combinational from state.
  - dmem_addr, dmem_wr, dmem_be and dmem_wdata hold stable.
  - On the edge where dmem_ack = 1: dmem_req <= 0, m_valid <= 1, state <= IDLE.
  - Load: m_wbr <= latched wbr, m_res <= aligned data. Store: m_wbr <= 0.
  - The upstream record held by the stall is consumed on the following IDLE edge.
- Big-endian lanes:
  - Byte ea[1:0] = k selects dmem_rdata[31-8k -: 8].
  - Half ea[1] = h selects dmem_rdata[31-16h -: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store data and enables:
  - SB: be = 4'b1000 >> ea[1:0], wdata = {4{rt[7:0]}}.
  - SH: be = ea[1] ? 4'b0011 : 4'b1100, wdata = {2{rt[15:0]}}.
  - SW: be = 4'b1111, wdata = rt. For loads be = 4'b1111.
- m_restart and m_restart_pc are 0 unless the trap feature fires.
- An ack that arrives while in IDLE is ignored.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Trap condition: a valid LH/LHU/SH with ea[0] = 1, or LW/SW with ea[1:0] != 0.
  - No dmem access is issued and the block stays in IDLE.
  - Next edge: m_valid <= 0, m_restart <= 1 (one cycle), m_restart_pc <= RESET_PC_VECTOR. The faulting PC is held in an internal register m_badpc.
- Undefined: ea low bits are ignored for alignment (the access uses the natural lane for ea[1] / ea[1:0] truncated to size), and m_restart stays 0.

Decomposition:
- Shared package/include: opcode constants (reusing the existing asm.v defines), 2-bit access size encoding, and the exception vector constant.
- One natural sub-module: load_align (combinational lane select plus sign/zero extension of dmem_rdata, driven by size, signedness and ea[1:0]).

Test Plan:
- ADDU record, x_res = 32'h12345678, wbr = 5 -> next cycle m_valid = 1, m_wbr = 5, m_res = 12345678, m_stall = 0.
- LB, base 32'h1000, offset 16'hFFFF (ea = 0FFF), rdata = 32'h000000F0 -> dmem_addr = 00000FFC; m_res = FFFFFFF0; LBU gives 000000F0.
- SH, ea = 32'h2002, rt = 32'hABCDBEEF -> dmem_be = 4'b0011, dmem_wdata = BEEFBEEF, m_wbr = 0 after ack.
- LW with ack delayed 3 cycles -> m_stall high 4 cycles, upstream record consumed exactly once after m_valid = 1.
- Reset_n low during WAIT, then an ack -> dmem_req drops immediately, m_valid stays 0, state IDLE.
- MISALIGN_TRAP_EN: LW, ea = 32'h1001 -> no dmem_req, m_restart = 1, m_restart_pc = BFC00380.
